// File: rtl/uart_rx_pkg.sv
// ============================================================================
//  uart_rx_pkg : register map, STATUS bit positions and receiver FSM states
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

   localparam logic [31:0] ADDR_RXDATA    = 32'h0000_0000;
   localparam logic [31:0] ADDR_STATUS    = 32'h0000_0004;
   localparam int          REG_SEL_BIT    = 2;

   localparam int          STAT_AVAIL     = 0;
   localparam int          STAT_OVERRUN   = 1;
   localparam int          STAT_FRAME_ERR = 2;
   localparam int          STAT_COUNT_LSB = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  uart_rx_fifo : synchronous receive FIFO; a pop and push in the same cycle
//                 both take effect even when full
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   localparam int CW = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A pop frees the slot the concurrent push needs, so full does not block it.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  uart_rx : memory-mapped 8N1 UART receiver on the picorv32 native bus
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUD_DIV   = 868,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   input  logic        serialIn
);

   localparam int               CNT_W     = $clog2(BAUD_DIV);
   localparam int               FCNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

   rx_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               sync1_q, sync2_q;
   logic               ready_q, ready_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               overrun_q, overrun_d;
   logic               frame_err_q, frame_err_d;

   logic               line;
   logic               expired;
   logic               rx_push;
   logic               ferr_set;
   logic               bus_sel;
   logic               access;
   logic               is_write;
   logic               is_status;
   logic               is_rxdata;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [7:0]         fifo_dout;
   logic [FCNT_W-1:0]  fifo_count;
   logic [31:0]        status_word;
   logic               ovr_set;
   logic               ovr_clr;
   logic               ferr_clr;
   logic               unused_bits;

   assign unused_bits = ^{mem_instr, mem_addr[31:3], mem_addr[1:0],
                          mem_wdata[31:3], mem_wdata[0], mem_wstrb[3:1]};

   assign line    = sync2_q;
   assign expired = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      rx_push   = 1'b0;
      ferr_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!line) begin
               cnt_d   = HALF_LOAD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (!expired) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!line) begin
               cnt_d     = FULL_LOAD;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!expired) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shift_d = {line, shift_q[7:1]};
               cnt_d   = FULL_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (!expired) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (line) begin
               rx_push = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ferr_set = 1'b1;
               state_d  = ST_BREAK;
            end
         end
         ST_BREAK: begin
            // A held-low line must go idle before another start bit is accepted.
            if (line) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus_sel   = enable && mem_valid;
   assign access    = bus_sel && !ready_q;
   assign is_write  = |mem_wstrb;
   assign is_status = (mem_addr[REG_SEL_BIT] == ADDR_STATUS[REG_SEL_BIT]);
   assign is_rxdata = (mem_addr[REG_SEL_BIT] == ADDR_RXDATA[REG_SEL_BIT]);

   assign fifo_pop  = access && !is_write && is_rxdata && !fifo_empty;
   assign ovr_clr   = access && is_write && is_status && mem_wstrb[0] && mem_wdata[STAT_OVERRUN];
   assign ferr_clr  = access && is_write && is_status && mem_wstrb[0] && mem_wdata[STAT_FRAME_ERR];
   assign ovr_set   = rx_push && fifo_full && !fifo_pop;

   always_comb begin
      status_word                              = '0;
      status_word[STAT_AVAIL]                  = !fifo_empty;
      status_word[STAT_OVERRUN]                = overrun_q;
      status_word[STAT_FRAME_ERR]              = frame_err_q;
      status_word[STAT_COUNT_LSB +: 8]         = 8'(fifo_count);

      ready_d = access;
      rdata_d = rdata_q;
      if (access) begin
         if (is_write) begin
            rdata_d = '0;
         end else if (is_status) begin
            rdata_d = status_word;
         end else begin
            rdata_d = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
         end
      end

      // Set has priority over a clear landing in the same cycle.
      overrun_d   = ovr_set  ? 1'b1 : (ovr_clr  ? 1'b0 : overrun_q);
      frame_err_d = ferr_set ? 1'b1 : (ferr_clr ? 1'b0 : frame_err_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         sync1_q     <= serialIn;
         sync2_q     <= sync1_q;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (fifo_pop),
      .din   (shift_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Shared bus wires: only drive them while this peripheral is addressed.
   assign mem_ready = bus_sel ? ready_q : 1'bz;
   assign mem_rdata = bus_sel ? rdata_q : 32'hzzzz_zzzz;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  tb_uart_rx : scoreboard bench for uart_rx with a queue-based receive model
//  Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

   localparam int BAUD  = 16;
   localparam int DEPTH = 4;
   // Edge count from the first start-bit drive to the stop-bit push:
   // 2 sync stages + 1 detect + half bit + start/8 data bits at full period.
   localparam int PUSH_EDGE = 3 + BAUD / 2 + 9 * BAUD;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        enable    = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [31:0] mem_addr  = 32'h0;
   logic        serialIn  = 1'b1;
   wire         mem_ready;
   wire  [31:0] mem_rdata;

   uart_rx #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .serialIn  (serialIn)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;

   // Reference model: received bytes in arrival order plus the two sticky flags.
   logic [7:0]  m_fifo[$];
   bit          m_ovr  = 1'b0;
   bit          m_ferr = 1'b0;

   logic [31:0] exp_q[$];
   string       name_q[$];
   string       mon_nm;
   logic [31:0] mon_exp;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s        = 32'h0;
      s[0]     = (m_fifo.size() != 0);
      s[1]     = m_ovr;
      s[2]     = m_ferr;
      s[15:8]  = 8'(m_fifo.size());
      return s;
   endfunction

   function automatic void m_rx(input logic [7:0] b);
      if (m_fifo.size() >= DEPTH) m_ovr = 1'b1;
      else                        m_fifo.push_back(b);
   endfunction

   // Scoreboard monitor: every read acknowledge consumes one expected word.
   always @(negedge clk) begin
      if (mem_ready === 1'b1 && mem_valid && enable && mem_wstrb == 4'h0) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got rdata %h expected no acknowledge", mem_rdata);
         end else begin
            mon_nm  = name_q.pop_front();
            mon_exp = exp_q.pop_front();
            check(mon_nm, mem_rdata, mon_exp);
         end
      end
   end

   // Called at a negedge; returns at a negedge.
   task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input string nm);
      logic [31:0] e;
      int          waited;
      if (strb == 4'h0) begin
         if (addr[2]) e = m_status();
         else if (m_fifo.size() != 0) e = {24'h0, m_fifo.pop_front()};
         else e = 32'h0;
         exp_q.push_back(e);
         name_q.push_back(nm);
      end else if (addr[2] && strb[0]) begin
         if (wdata[1]) m_ovr  = 1'b0;
         if (wdata[2]) m_ferr = 1'b0;
      end
      enable    = 1'b1;
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wstrb = strb;
      mem_wdata = wdata;
      mem_instr = 1'($urandom_range(0, 1));
      waited    = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (mem_ready !== 1'b1 && waited < 8);
      check({nm, "_ack"}, {31'h0, mem_ready}, 32'h1);
      check({nm, "_latency"}, waited, 32'd1);
      @(negedge clk);
      check({nm, "_ready_pulse"}, {31'h0, mem_ready}, 32'h0);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      enable    = 1'($urandom_range(0, 1));
      #1;
      check({nm, "_ready_released"}, {31'h0, mem_ready === 1'b1}, 32'h0);
      @(negedge clk);
   endtask

   task automatic rd_status(input string nm);
      bus_xfer(32'h4, 4'h0, 32'h0, nm);
   endtask

   task automatic rd_data(input string nm);
      bus_xfer(32'h0, 4'h0, 32'h0, nm);
   endtask

   // Called at a negedge; returns at a negedge with the line idle.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      serialIn = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serialIn = b[i];
         repeat (BAUD) @(negedge clk);
      end
      if (stop_ok) begin
         serialIn = 1'b1;
         repeat (BAUD) @(negedge clk);
      end else begin
         serialIn = 1'b0;
         repeat (40) @(negedge clk);
         serialIn = 1'b1;
         repeat (BAUD) @(negedge clk);
      end
   endtask

   task automatic glitch(input int len);
      serialIn = 1'b0;
      repeat (len) @(negedge clk);
      serialIn = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
   endtask

   task automatic foreign_access();
      enable    = 1'b0;
      mem_valid = 1'b1;
      mem_addr  = 32'h0;
      mem_wstrb = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("foreign_ready", {31'h0, mem_ready === 1'b1}, 32'h0);
      end
      mem_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      int         nf;
      bit         ok;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_ready", {31'h0, mem_ready === 1'b1}, 32'h0);
      @(negedge clk);
      rd_status("reset_status");

      // Single frame
      send_frame(8'hA5, 1'b1);
      m_rx(8'hA5);
      rd_status("a5_status");
      rd_data("a5_data");
      rd_status("a5_status_after");

      // Short low pulse must not start a frame
      glitch(5);
      rd_status("glitch_status");

      // Overrun
      for (int i = 1; i <= 6; i++) begin
         send_frame(8'(i), 1'b1);
         m_rx(8'(i));
      end
      rd_status("ovr_status");
      foreign_access();
      for (int i = 0; i < 4; i++) rd_data("ovr_data");
      rd_data("empty_data");
      bus_xfer(32'h4, 4'h1, 32'h2, "ovr_clear");
      rd_status("ovr_cleared");

      // Framing error and recovery
      send_frame(8'h3C, 1'b0);
      m_ferr = 1'b1;
      rd_status("ferr_status");
      send_frame(8'h55, 1'b1);
      m_rx(8'h55);
      rd_data("after_ferr_data");
      bus_xfer(32'h4, 4'h1, 32'h4, "ferr_clear");
      rd_status("ferr_cleared");

      // Full FIFO, read ack lands on the stop-bit push edge
      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 1'b1);
         m_rx(8'(i));
      end
      fork
         send_frame(8'h05, 1'b1);
         begin
            repeat (PUSH_EDGE - 1) @(negedge clk);
            rd_data("simul_data");
         end
      join
      m_rx(8'h05);
      rd_status("simul_status");
      for (int i = 0; i < 4; i++) rd_data("simul_drain");

      // Randomised traffic
      for (int it = 0; it < 6; it++) begin
         nf = $urandom_range(1, 5);
         for (int j = 0; j < nf; j++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok);
            if (ok) m_rx(b);
            else    m_ferr = 1'b1;
            if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 6));
         end
         rd_status("rand_status");
         for (int k = 0; k <= nf; k++) rd_data("rand_data");
         bus_xfer({29'h0, 1'($urandom_range(0, 1)), 2'b00}, 4'($urandom_range(1, 15)),
                  $urandom, "rand_write");
         rd_status("rand_status_after");
      end

      // Reset in the middle of a frame with one byte queued
      send_frame(8'h11, 1'b1);
      m_rx(8'h11);
      serialIn = 1'b0;
      repeat (BAUD) @(negedge clk);
      serialIn = 1'b1;
      repeat (BAUD + BAUD / 2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_ready", {31'h0, mem_ready === 1'b1}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      m_fifo.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      repeat (2 * BAUD) @(negedge clk);
      rd_status("midreset_status");
      rd_data("midreset_data");

      repeat (4) @(negedge clk);
      check("scoreboard_drain", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
